// File: rtl/mult_host_pkg.sv
// Shared constants and state encoding for the multiplier sequencing front end.
package mult_host_pkg;

  localparam int OP_W            = 8;
  localparam int PROD_W          = 16;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_LAUNCH = 3'b001,
    ST_WAIT   = 3'b010,
    ST_RESP   = 3'b011
  } state_t;

endpackage

// File: rtl/mult_host_if.sv
// Request, response and multiplier-side signals of mult_host bundled as one interface.
interface mult_host_if;
  import mult_host_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_a;
  logic [OP_W-1:0]   req_b;

  logic [OP_W-1:0]   mult_dataa;
  logic [OP_W-1:0]   mult_datab;
  logic              mult_start;
  logic              mult_done;
  logic [PROD_W-1:0] mult_product;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [PROD_W-1:0] rsp_product;
  logic              rsp_err;

  // slave is the host block itself; master is its surrounding environment
  modport slave (
    input  req_valid, req_a, req_b, mult_done, mult_product, rsp_ready,
    output req_ready, mult_dataa, mult_datab, mult_start, rsp_valid, rsp_product, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b, mult_done, mult_product, rsp_ready,
    input  req_ready, mult_dataa, mult_datab, mult_start, rsp_valid, rsp_product, rsp_err
  );

endinterface

// File: rtl/mult_host_timer.sv
// Watchdog counter for the WAIT phase; expired flags the last allowed wait cycle.
module mult_host_timer
  import mult_host_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic reset_a,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mult_host.sv
// Sequencer that feeds operand pairs to the 8x8 multiplier, pulses start, and returns the
// product (or a watchdog error) over a valid/ready response port.
module mult_host
  import mult_host_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = 8
) (
  input  logic       clk,
  input  logic       reset_a,
  mult_host_if.slave bus,
  output logic       busy,
  output logic [2:0] state_out
);

  state_t            state, next_state;
  logic              load_ops, cap_done, cap_err;
  logic              timer_clr, timer_en, expired;
  logic              ready_c, start_c, valid_c;
  logic [OP_W-1:0]   dataa, datab;
  logic [PROD_W-1:0] product;
  logic              err;

  mult_host_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
    .clk     (clk),
    .reset_a (reset_a),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != ST_IDLE);
    end
  end

  // Handshake outputs decode only the state register, so no input reaches an output combinationally
  always_comb begin
    next_state = state;
    ready_c    = 1'b0;
    start_c    = 1'b0;
    valid_c    = 1'b0;
    load_ops   = 1'b0;
    cap_done   = 1'b0;
    cap_err    = 1'b0;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) begin
          load_ops   = 1'b1;
          next_state = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        start_c    = 1'b1;
        timer_clr  = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        if (bus.mult_done) begin
          cap_done   = 1'b1;
          next_state = ST_RESP;
        end else if (expired) begin
          cap_err    = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        valid_c = 1'b1;
        if (bus.rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      dataa <= '0;
      datab <= '0;
    end else if (load_ops) begin
      dataa <= bus.req_a;
      datab <= bus.req_b;
    end
  end

  // A done in the expiry cycle takes priority in the next-state logic, so err is only set when done is absent
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      product <= '0;
      err     <= 1'b0;
    end else if (cap_done) begin
      product <= bus.mult_product;
      err     <= 1'b0;
    end else if (cap_err) begin
      product <= '0;
      err     <= 1'b1;
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.mult_start  = start_c;
  assign bus.rsp_valid   = valid_c;
  assign bus.mult_dataa  = dataa;
  assign bus.mult_datab  = datab;
  assign bus.rsp_product = product;
  assign bus.rsp_err     = err;
  assign state_out       = state;

endmodule

// File: tb/tb_mult_host.sv
// Self-checking bench for mult_host: a transaction-age reference model, a behavioural multiplier
// with programmable latency, directed corner cases and a randomized traffic phase.
module tb_mult_host;
  import mult_host_pkg::*;

  localparam int T     = TIMEOUT_DEFAULT;
  localparam int NEVER = 255;

  logic       clk = 1'b0;
  logic       reset_a;
  logic       busy;
  logic [2:0] state_out;
  int         checks   = 0;
  int         failures = 0;
  int         lat_next = 1;

  mult_host_if bus ();

  mult_host dut (
    .clk       (clk),
    .reset_a   (reset_a),
    .bus       (bus.slave),
    .busy      (busy),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  // Reference model: a transaction is tracked only by its age in cycles since the start pulse
  bit         m_active = 1'b0;
  int         m_age    = 0;
  int         m_lat    = 0;
  logic [7:0] m_a      = '0;
  logic [7:0] m_b      = '0;

  function automatic bit done_ok(input int lat);
    return (lat >= 1) && (lat <= T);
  endfunction

  function automatic int resp_age(input int lat);
    return done_ok(lat) ? lat + 1 : T + 1;
  endfunction

  always @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      m_active = 1'b0;
      m_age    = 0;
      m_a      = '0;
      m_b      = '0;
    end else if (m_active) begin
      if (m_age >= resp_age(m_lat) && bus.rsp_ready) m_active = 1'b0;
      else m_age++;
    end else if (bus.req_valid) begin
      m_active = 1'b1;
      m_age    = 0;
      m_lat    = lat_next;
      m_a      = bus.req_a;
      m_b      = bus.req_b;
    end
  end

  // Behavioural multiplier: done arrives m_lat cycles after the start pulse it observes
  int mm_cnt = 0;
  always @(negedge clk or posedge reset_a) begin
    if (reset_a) begin
      mm_cnt           = 0;
      bus.mult_done    = 1'b0;
      bus.mult_product = '0;
    end else begin
      bus.mult_done    = 1'b0;
      bus.mult_product = 16'($urandom);
      if (mm_cnt > 0) begin
        mm_cnt--;
        if (mm_cnt == 0) begin
          bus.mult_done    = 1'b1;
          bus.mult_product = 16'(bus.mult_dataa) * 16'(bus.mult_datab);
        end
      end
      if (bus.mult_start === 1'b1) begin
        if (m_lat == 0) begin
          bus.mult_done    = 1'b1;
          bus.mult_product = 16'(bus.mult_dataa) * 16'(bus.mult_datab);
          mm_cnt           = 0;
        end else begin
          mm_cnt = (m_lat == NEVER) ? 0 : m_lat;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [2:0] es;
    if (!m_active)                    es = 3'd0;
    else if (m_age == 0)              es = 3'd1;
    else if (m_age < resp_age(m_lat)) es = 3'd2;
    else                              es = 3'd3;
    check_output("state_out", state_out, es);
    check_output("busy", busy, es != 3'd0);
    check_output("req_ready", bus.req_ready, es == 3'd0);
    check_output("mult_start", bus.mult_start, es == 3'd1);
    check_output("rsp_valid", bus.rsp_valid, es == 3'd3);
    check_output("mult_dataa", bus.mult_dataa, m_a);
    check_output("mult_datab", bus.mult_datab, m_b);
    if (es == 3'd3) begin
      check_output("rsp_product", bus.rsp_product, done_ok(m_lat) ? 16'(m_a) * 16'(m_b) : 16'h0);
      check_output("rsp_err", bus.rsp_err, !done_ok(m_lat));
    end
  endtask

  always @(posedge clk) begin
    #2;
    check_cycle();
  end

  // Presents one pair from IDLE; returns at the falling edge inside the start-pulse cycle
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input int lat);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    lat_next      = lat;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n, output int starts);
    n      = 0;
    starts = 0;
    while (bus.rsp_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
      if (bus.mult_start === 1'b1) starts++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $display("[TB] FAIL rsp_wait: got no rsp_valid expected one within 64 cycles");
    end
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)  return $urandom_range(1, 6);
    if (r == 6) return T;
    if (r == 7) return T + $urandom_range(1, 2);
    if (r == 8) return 0;
    return NEVER;
  endfunction

  initial begin
    int n, starts;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    reset_a       = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset_state", state_out, 3'b000);
    check_output("reset_req_ready", bus.req_ready, 1'b1);
    check_output("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check_output("reset_rsp_product", bus.rsp_product, 16'h0);
    check_output("reset_rsp_err", bus.rsp_err, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    reset_a = 1'b0;

    $display("[TB] basic multiply with backpressure");
    apply_stimulus(8'hFF, 8'hFF, 5);
    check_output("basic_start", bus.mult_start, 1'b1);
    wait_rsp(n, starts);
    check_output("basic_latency", n, 6);
    check_output("basic_extra_starts", starts, 0);
    check_output("basic_product", bus.rsp_product, 16'hFE01);
    check_output("basic_err", bus.rsp_err, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check_output("bp_product", bus.rsp_product, 16'hFE01);
      check_output("bp_req_ready", bus.req_ready, 1'b0);
    end
    release_rsp();
    check_output("bp_idle", state_out, 3'b000);
    check_output("bp_rsp_valid", bus.rsp_valid, 1'b0);

    $display("[TB] watchdog timeout");
    apply_stimulus(8'h12, 8'h34, NEVER);
    wait_rsp(n, starts);
    check_output("to_latency", n, T + 1);
    check_output("to_err", bus.rsp_err, 1'b1);
    check_output("to_product", bus.rsp_product, 16'h0);
    release_rsp();

    $display("[TB] done on the expiry cycle");
    apply_stimulus(8'h19, 8'h7D, T);
    wait_rsp(n, starts);
    check_output("col_latency", n, T + 1);
    check_output("col_err", bus.rsp_err, 1'b0);
    check_output("col_product", bus.rsp_product, 16'h0C35);
    release_rsp();

    $display("[TB] reset during wait");
    apply_stimulus(8'h55, 8'h66, NEVER);
    repeat (3) @(negedge clk);
    check_output("rst_in_wait", state_out, 3'b010);
    reset_a = 1'b1;
    #1;
    check_output("rst_async_state", state_out, 3'b000);
    check_output("rst_async_valid", bus.rsp_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset_a = 1'b0;
    repeat (T + 4) @(negedge clk);
    check_output("rst_no_rsp", bus.rsp_valid, 1'b0);
    apply_stimulus(8'h03, 8'h04, 2);
    wait_rsp(n, starts);
    check_output("post_rst_latency", n, 3);
    check_output("post_rst_product", bus.rsp_product, 16'h000C);
    release_rsp();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_a     = 8'($urandom);
      bus.req_b     = 8'($urandom);
      lat_next      = pick_lat();
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      reset_a       = (i == 700);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset_a       = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_host.md
# mult_host

Sequencing front end for the 8x8 sequential multiplier. It accepts operand pairs over a valid/ready request port and registers them onto the multiplier data inputs. It issues a single-cycle `mult_start`, waits for `mult_done`, captures the 16-bit product and returns it on a valid/ready response port. The block is the initiator that drives the multiplier controller's `start` input and consumes its `done` output; a watchdog turns a missing `done` into an error response.

## Interface
- `TIMEOUT`, default 15: maximum WAIT cycles before an error response; legal range 1..255.
- `TW`, default 8: width of the watchdog counter; must hold `TIMEOUT`.
- `clk`  in  1  rising-edge clock
- `reset_a`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  operand pair available
- `req_ready`  out  1  block can accept a pair
- `req_a`  in  8  multiplicand
- `req_b`  in  8  multiplier
- `mult_dataa`  out  8  operand A to multiplier datapath
- `mult_datab`  out  8  operand B to multiplier datapath
- `mult_start`  out  1  one-cycle start pulse to multiplier controller
- `mult_done`  in  1  multiplier controller done
- `mult_product`  in  16  multiplier product register
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer accepts response
- `rsp_product`  out  16  captured product; 0 on error
- `rsp_err`  out  1  1 = watchdog timeout
- `busy`  out  1  1 whenever state is not IDLE
- `state_out`  out  3  current state encoding, for debug

## Operation
- States and encodings: IDLE = 000, LAUNCH = 001, WAIT = 010, RESP = 011. Encodings 100..111 are illegal and return to IDLE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid & req_ready`: register `req_a`/`req_b` into `mult_dataa`/`mult_datab`, then go to LAUNCH.
- **LAUNCH**
  - `mult_start` = 1 for exactly this cycle.
  - Clear the watchdog to 0.
  - Go to WAIT unconditionally.
  - `mult_done` is ignored in this state.
- **WAIT**
  - Watchdog increments once per cycle.
  - If `mult_done` = 1: capture `mult_product` into `rsp_product`, set `rsp_err` = 0, go to RESP.
  - Else if watchdog = `TIMEOUT`-1: set `rsp_product` = 0, `rsp_err` = 1, go to RESP.
  - If `mult_done` arrives in the same cycle as the timeout condition, `mult_done` wins.
- **RESP**
  - `rsp_valid` = 1; `rsp_product` and `rsp_err` are held stable.
  - On `rsp_ready` = 1, go to IDLE. `req_ready` is 0 in this state, so request and response never overlap.
- `mult_dataa`/`mult_datab` stay stable from LAUNCH until the next accepted request; they are never changed mid-operation.
- `mult_start` is never asserted outside LAUNCH, which guarantees the multiplier controller never sees `start` during a calculation.

## Timing
- Reset values (while `reset_a` = 1, asynchronously):
  - state = IDLE, `req_ready` = 1.
  - `mult_start`, `rsp_valid`, `rsp_err`, `busy` = 0.
  - `mult_dataa`, `mult_datab`, `rsp_product`, watchdog = 0.
  - `state_out` = 000.
- Reset mid-operation aborts the transaction with no response. The multiplier controller shares `reset_a` and returns to idle with it.
- Accept edge N → `mult_start` high during cycle N+1 → first `mult_done` sample at edge N+2.
- Done sampled at edge D → `rsp_valid` high from cycle D+1.
- Minimum request-to-response latency is 3 cycles, plus the multiplier's own latency.
- Timeout: with no `mult_done`, `rsp_valid` rises `TIMEOUT`+1 cycles after LAUNCH.
- Back-to-back throughput: the response handshake at edge R allows the next request to be accepted at edge R+1 at the earliest.
- `busy` and `state_out` are registered outputs; no combinational path from any input to any output.

## Structure
- Package `mult_host_pkg`:
  - state encoding constants (IDLE/LAUNCH/WAIT/RESP).
  - operand width 8 and product width 16 constants.
  - default `TIMEOUT`.
- One sub-module, `mult_host_timer`:
  - `TW`-bit watchdog with synchronous clear, enable and `expired` flag (count = `TIMEOUT`-1).
  - Same `clk`/`reset_a` as the parent.
- Top level holds the FSM, the operand registers and the response registers.

## Test plan
- Reset: hold `reset_a` = 1 for 2 cycles → all outputs at reset values, `state_out` = 000, `req_ready` = 1.
- Basic multiply: `req_a` = 8'hFF, `req_b` = 8'hFF accepted; model asserts `mult_done` 5 cycles after start with product 16'hFE01 → exactly one `mult_start` pulse, `rsp_product` = 16'hFE01, `rsp_err` = 0.
- Backpressure: hold `rsp_ready` = 0 for 6 cycles after `rsp_valid` → `rsp_product` stable, `req_ready` = 0 throughout; `rsp_ready` = 1 → IDLE on the next cycle.
- Timeout: `TIMEOUT` = 4, model never asserts `mult_done` → `rsp_valid` 5 cycles after LAUNCH, `rsp_err` = 1, `rsp_product` = 0.
- Done/timeout collision: `mult_done` on the expiry cycle, product 16'h0C35 (`req_a` = 8'h19, `req_b` = 8'h7D) → `rsp_err` = 0, `rsp_product` = 16'h0C35.
- Reset mid-WAIT: assert `reset_a` during WAIT → immediate IDLE, no `rsp_valid`; next request 8'h03 × 8'h04 returns 16'h000C.
